// File: rtl/srl_mon_pkg.sv
// Shared definitions for the SRL equivalence monitor: FSM state encoding,
// default parameter values and the saturating-increment helper.
package srl_mon_pkg;

  // Monitor phases: ignore samples while the pipeline fills, then compare.
  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_CHECK  = 1'b1
  } mon_state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CNT_W  = 16;

  // Increment value, holding at the all-ones value of a width-bit counter.
  // Counters wider than 32 bits are not supported by this helper.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    if (width >= 32) max_v = 32'hFFFF_FFFF;
    else             max_v = (32'd1 << width) - 32'd1;
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the mismatch count and the cycle counter.
// A clear on the same edge as an increment leaves the counter at 1, so the
// sample that coincides with the clear is still counted.
module sat_counter
  import srl_mon_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register: reset wins, then clear (plus the coincident increment), then saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), W));
    end
  end

endmodule

// File: rtl/srl_equiv_monitor.sv
// Compares the reference shift-register lanes (pat) against the netlist
// lanes (test) after a settle window and records a sticky error, a
// saturating mismatch count and the cycle/lanes of the first mismatch.
// Optional build macro SRL_MON_XCHECK_EN (simulation only): a lane also
// mismatches when test is X/Z while pat is known.
module srl_equiv_monitor
  import srl_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             clear,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] pat,
  input  logic [WIDTH-1:0] test,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff,
  output logic             armed,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  mon_state_e       state, state_nxt;
  logic [SC_W-1:0]  settle_cnt, settle_nxt;
  logic [WIDTH-1:0] diff;
  logic             hit;

`ifdef SRL_MON_XCHECK_EN
  // Per-lane case-inequality so an X/Z netlist lane against a known reference flags.
  always_comb begin
    diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = (pat[i] !== test[i]) & ~mask[i];
    end
  end
`else
  // Plain lane compare with masked lanes excluded.
  always_comb begin
    diff = (pat ^ test) & ~mask;
  end
`endif

  assign hit   = (state == ST_CHECK) && valid_in && (|diff);
  assign armed = (state == ST_CHECK);

  // State and settle-progress register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next state: count valid samples through the settle window; clear restarts it.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_SETTLE: begin
        if (SETTLE == 0) begin
          state_nxt = ST_CHECK;
        end else if (clear) begin
          settle_nxt = '0;
        end else if (valid_in) begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt  = ST_CHECK;
            settle_nxt = '0;
          end else begin
            settle_nxt = settle_cnt + SC_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if (clear && (SETTLE > 0)) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_SETTLE;
        settle_nxt = '0;
      end
    endcase
  end

  // Sticky error and first-failure capture; a clear coinciding with a hit recaptures.
  always_ff @(posedge clk) begin
    if (rst) begin
      err         <= 1'b0;
      first_cycle <= '0;
      first_diff  <= '0;
    end else if (hit && (!err || clear)) begin
      err         <= 1'b1;
      first_cycle <= cycle_cnt;
      first_diff  <= diff;
    end else if (clear) begin
      err         <= 1'b0;
      first_cycle <= '0;
      first_diff  <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (hit),
    .q   (err_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (1'b1),
    .q   (cycle_cnt)
  );

endmodule

// File: tb/tb_srl_equiv_monitor.sv
// Self-checking bench for srl_equiv_monitor. Three instances share one input
// stream: A (SETTLE=4, CNT_W=16), B (SETTLE=0, CNT_W=16), C (SETTLE=2, CNT_W=4).
module tb_srl_equiv_monitor;

  logic       clk = 1'b0;
  logic       rst, valid_in, clear;
  logic [7:0] mask, pat, test;

  logic        a_err, a_armed;
  logic [15:0] a_cnt, a_fc, a_cyc;
  logic [7:0]  a_fd;
  logic        b_err, b_armed;
  logic [15:0] b_cnt, b_fc, b_cyc;
  logic [7:0]  b_fd;
  logic        c_err, c_armed;
  logic [3:0]  c_cnt, c_fc, c_cyc;
  logic [7:0]  c_fd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  srl_equiv_monitor #(.WIDTH(8), .SETTLE(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .clear(clear), .mask(mask), .pat(pat), .test(test),
    .err(a_err), .err_count(a_cnt), .first_cycle(a_fc), .first_diff(a_fd), .armed(a_armed), .cycle_cnt(a_cyc));

  srl_equiv_monitor #(.WIDTH(8), .SETTLE(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .clear(clear), .mask(mask), .pat(pat), .test(test),
    .err(b_err), .err_count(b_cnt), .first_cycle(b_fc), .first_diff(b_fd), .armed(b_armed), .cycle_cnt(b_cyc));

  srl_equiv_monitor #(.WIDTH(8), .SETTLE(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .valid_in(valid_in), .clear(clear), .mask(mask), .pat(pat), .test(test),
    .err(c_err), .err_count(c_cnt), .first_cycle(c_fc), .first_diff(c_fd), .armed(c_armed), .cycle_cnt(c_cyc));

  // Reference model state: counts of things, not the RTL's FSM encoding.
  typedef struct {
    bit err;
    int cnt;
    int fc;
    int fd;
    int cyc;
    int vcount;
    bit armed;
  } model_t;

  model_t ma, mb, mc;

  typedef struct {
    bit         rst;
    bit         valid;
    bit         clr;
    logic [7:0] mask;
    logic [7:0] pat;
    logic [7:0] test;
    bit         e_err;
    int         e_cnt;
    int         e_fc;
    int         e_fd;
    bit         e_armed;
    int         e_cyc;
  } vec_t;

  vec_t vecs[26];

  // One posedge of the monitor's rules for a given SETTLE / counter width.
  function automatic model_t modelStep(model_t m, int s, int cw, bit r, bit v, bit c,
                                       logic [7:0] mk, logic [7:0] pt, logic [7:0] ts);
    model_t n;
    int     maxv;
    int     d;
    n    = m;
    maxv = (1 << cw) - 1;
    d    = int'((pt ^ ts) & ~mk);
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (c) begin
      n.err = 0;
      n.cnt = 0;
      n.fc  = 0;
      n.fd  = 0;
    end
    if (m.armed && v && d != 0) begin
      if (!n.err) begin
        n.fc = m.cyc;
        n.fd = d;
      end
      n.err = 1;
      if (n.cnt < maxv) n.cnt = n.cnt + 1;
    end
    if (m.cyc < maxv) n.cyc = m.cyc + 1;
    if (c && s > 0) n.vcount = 0;
    else if (v)     n.vcount = m.vcount + 1;
    n.armed = (s == 0) ? 1'b1 : (n.vcount >= s);
    return n;
  endfunction

  task automatic checkOutput(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkDut(input string tag, input model_t m, input bit e, input int cnt,
                          input int fc, input int fd, input bit am, input int cyc);
    checkOutput({tag, ".err"},         e,   m.err);
    checkOutput({tag, ".err_count"},   cnt, m.cnt);
    checkOutput({tag, ".first_cycle"}, fc,  m.fc);
    checkOutput({tag, ".first_diff"},  fd,  m.fd);
    checkOutput({tag, ".armed"},       am,  m.armed);
    checkOutput({tag, ".cycle_cnt"},   cyc, m.cyc);
  endtask

  // Drive one cycle of inputs, advance the models at the edge, compare just after it.
  task automatic applyStimulus(input bit r, input bit v, input bit c,
                               input logic [7:0] mk, input logic [7:0] pt, input logic [7:0] ts);
    rst = r; valid_in = v; clear = c; mask = mk; pat = pt; test = ts;
    @(posedge clk);
    ma = modelStep(ma, 4, 16, r, v, c, mk, pt, ts);
    mb = modelStep(mb, 0, 16, r, v, c, mk, pt, ts);
    mc = modelStep(mc, 2, 4,  r, v, c, mk, pt, ts);
    #1;
    checkDut("A", ma, a_err, int'(a_cnt), int'(a_fc), int'(a_fd), a_armed, int'(a_cyc));
    checkDut("B", mb, b_err, int'(b_cnt), int'(b_fc), int'(b_fd), b_armed, int'(b_cyc));
    checkDut("C", mc, c_err, int'(c_cnt), int'(c_fc), int'(c_fd), c_armed, int'(c_cyc));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] p;
    logic [7:0] flip;
    ma = '{default: 0};
    mb = '{default: 0};
    mc = '{default: 0};
    rst = 1'b1; valid_in = 1'b0; clear = 1'b0; mask = '0; pat = '0; test = '0;

    // Hand-derived expectations for instance A (SETTLE=4, CNT_W=16).
    vecs[0]  = '{1,0,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,0, 0};
    vecs[1]  = '{1,0,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,0, 0};
    vecs[2]  = '{0,1,0,8'h00,8'hA5,8'hA4, 0,0, 0,8'h00,0, 1};
    vecs[3]  = '{0,1,0,8'h00,8'hA5,8'hA4, 0,0, 0,8'h00,0, 2};
    vecs[4]  = '{0,1,0,8'h00,8'hA5,8'hA4, 0,0, 0,8'h00,0, 3};
    vecs[5]  = '{0,1,0,8'h00,8'hA5,8'hA4, 0,0, 0,8'h00,1, 4};
    vecs[6]  = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1, 5};
    vecs[7]  = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1, 6};
    vecs[8]  = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1, 7};
    vecs[9]  = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1, 8};
    vecs[10] = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1, 9};
    vecs[11] = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1,10};
    vecs[12] = '{0,1,0,8'h00,8'hA5,8'h24, 1,1,10,8'h81,1,11};
    vecs[13] = '{0,1,0,8'h00,8'hA5,8'hA5, 1,1,10,8'h81,1,12};
    vecs[14] = '{0,1,0,8'h00,8'hA5,8'hA7, 1,2,10,8'h81,1,13};
    vecs[15] = '{0,1,0,8'h01,8'hA5,8'hA4, 1,2,10,8'h81,1,14};
    vecs[16] = '{0,1,0,8'h00,8'hA5,8'hA4, 1,3,10,8'h81,1,15};
    vecs[17] = '{0,0,0,8'h00,8'hA5,8'h00, 1,3,10,8'h81,1,16};
    vecs[18] = '{0,1,1,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,0,17};
    vecs[19] = '{0,1,0,8'h00,8'hA5,8'hA4, 0,0, 0,8'h00,0,18};
    vecs[20] = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,0,19};
    vecs[21] = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,0,20};
    vecs[22] = '{0,1,0,8'h00,8'hA5,8'hA5, 0,0, 0,8'h00,1,21};
    vecs[23] = '{0,1,0,8'h00,8'h3C,8'h2C, 1,1,21,8'h10,1,22};
    vecs[24] = '{0,1,1,8'hF0,8'hFF,8'h00, 1,1,22,8'h0F,0,23};
    vecs[25] = '{1,1,0,8'h00,8'hFF,8'h00, 0,0, 0,8'h00,0, 0};

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].clr, vecs[i].mask, vecs[i].pat, vecs[i].test);
      checkOutput($sformatf("vec%0d.err", i),         a_err,        vecs[i].e_err);
      checkOutput($sformatf("vec%0d.err_count", i),   int'(a_cnt),  vecs[i].e_cnt);
      checkOutput($sformatf("vec%0d.first_cycle", i), int'(a_fc),   vecs[i].e_fc);
      checkOutput($sformatf("vec%0d.first_diff", i),  int'(a_fd),   vecs[i].e_fd);
      checkOutput($sformatf("vec%0d.armed", i),       a_armed,      vecs[i].e_armed);
      checkOutput($sformatf("vec%0d.cycle_cnt", i),   int'(a_cyc),  vecs[i].e_cyc);
    end

    // SETTLE=0: three errors, then clear together with a new mismatch.
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkOutput("b.armed_after_rst", b_armed, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h11);
    checkOutput("b.cnt_before_clear", int'(b_cnt), 3);
    checkOutput("b.fc_before_clear",  int'(b_fc),  1);
    applyStimulus(0, 1, 1, 8'h00, 8'h00, 8'h42);
    checkOutput("b.err_clear_hit", b_err,         1);
    checkOutput("b.cnt_clear_hit", int'(b_cnt),   1);
    checkOutput("b.fc_clear_hit",  int'(b_fc),    4);
    checkOutput("b.fd_clear_hit",  int'(b_fd),    8'h42);
    checkOutput("b.armed_clear",   b_armed,       1);

    // CNT_W=4: continuous mismatches saturate the count and the cycle counter.
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 22; i++) applyStimulus(0, 1, 0, 8'h00, 8'hFF, 8'h00);
    checkOutput("c.cnt_sat",  int'(c_cnt), 15);
    checkOutput("c.err_sat",  c_err,       1);
    checkOutput("c.cyc_sat",  int'(c_cyc), 15);
    checkOutput("c.fc_first", int'(c_fc),  2);
    checkOutput("a.cnt_run",  int'(a_cnt), 18);

    // Randomized traffic against the models.
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 400; i++) begin
      p    = 8'($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 31) == 0), 8'($urandom & $urandom & $urandom),
                    p, p ^ flip);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
